vga_pixel_fetch: RTL and testbench

- Upstream feeder for the VGA timing/serialiser stage.
- Prefetches 1bpp framebuffer bytes from the shared SRAM read port into a small FIFO.
- Presents the next byte on pixels[7:0], one byte per pixel_req from the VGA stage, which shifts it out as 8 pixels.
- Restarts at address 0 on each frame_start pulse and flushes any stale prefetched or in-flight data.

---
 rtl/vga_pixel_fetch.sv | 162 ++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch
//   Prefetches 1bpp framebuffer bytes from the shared SRAM read port into a
//   small FIFO and hands one byte per pixel_req to the VGA serialiser.
//   A frame_start pulse restarts fetching at address 0 and throws away any
//   bytes that were prefetched or still in flight for the previous frame.
//
// Ports
//   clk          pixel clock
//   reset        asynchronous reset, active low
//   frame_start  1-cycle pulse, start of vertical blanking
//   pixel_req    1-cycle pulse, VGA stage consumes one byte
//   pixels       registered byte for the VGA stage (00 on underflow)
//   underflow    sticky: byte requested while FIFO empty during FETCH
//   mem_rd       read request, held until mem_ack
//   mem_addr     read address, stable while mem_rd && !mem_ack
//   mem_ack      request accepted this cycle
//   mem_valid    in-order read data strobe
//   mem_data     read data
//
// state | meaning
// IDLE  | after reset, nothing fetched until the first frame_start
// FETCH | keeping FIFO + in-flight reads topped up to DEPTH
// FLUSH | waiting for stale reads (and a held request) to drain

module vga_pixel_fetch #(
  parameter int ADDR_W      = 18,
  parameter int FRAME_BYTES = 38400,
  parameter int DEPTH       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pixel_req,
  output logic [7:0]        pixels,
  output logic              underflow,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_valid,
  input  logic [7:0]        mem_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);
  localparam logic [CW:0]       DEPTH_W   = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] addr_src, addr_inc;
  logic [CW-1:0]     outstanding, outstanding_n;
  logic [CW-1:0]     fifo_count, fifo_count_n;
  logic [CW-1:0]     discard, discard_n;
  logic [CW:0]       inflight_n;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [7:0]        fifo_mem [DEPTH];
  logic              ack, hold, drop, push, pop, mem_rd_n, launch;

  assign ack  = mem_rd & mem_ack;
  assign hold = mem_rd & ~mem_ack;
  assign drop = mem_valid & (discard != '0);
  // Data landing in the same cycle as frame_start belongs to the old frame.
  assign push = mem_valid & (discard == '0) & ~frame_start;
  assign pop  = pixel_req & (fifo_count != '0);

  assign outstanding_n = outstanding + CW'(ack) - CW'(mem_valid);
  assign fifo_count_n  = frame_start ? '0 : fifo_count + CW'(push) - CW'(pop);

  // Request decision looks at next-cycle occupancy so back-to-back acks keep
  // mem_rd asserted, and the first request follows frame_start by one cycle.
  assign inflight_n = {1'b0, fifo_count_n} + {1'b0, outstanding_n};
  assign mem_rd_n   = hold | ((state_n == FETCH) && (inflight_n < DEPTH_W));
  assign launch     = mem_rd_n & ~hold;

  // The address counter advances when a request is launched rather than when
  // it is acked, so a request held across frame_start keeps its old address
  // while the counter has already restarted at 0.
  assign addr_src = frame_start ? '0 : addr_cnt;
  assign addr_inc = (addr_src == LAST_ADDR) ? '0 : addr_src + ADDR_W'(1);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (frame_start) state_n = FETCH;
      FETCH:   if (frame_start) state_n = FLUSH;
      FLUSH:   if (!frame_start && (outstanding == '0) && !mem_rd) state_n = FETCH;
      default: state_n = IDLE;
    endcase
  end

  // Everything already in flight at frame_start is stale. A beat returning in
  // that same cycle is already excluded from outstanding_n (and is dropped by
  // the FIFO clear), so it is not counted twice.
  always_comb begin
    discard_n = discard;
    if (frame_start)
      discard_n = outstanding_n;
    else
      discard_n = discard - CW'(drop) + CW'(ack && (state == FLUSH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      addr_cnt    <= '0;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pixels      <= 8'h00;
      underflow   <= 1'b0;
    end else begin
      state       <= state_n;
      mem_rd      <= mem_rd_n;
      outstanding <= outstanding_n;
      discard     <= discard_n;
      fifo_count  <= fifo_count_n;

      if (launch) begin
        mem_addr <= addr_src;
        addr_cnt <= addr_inc;
      end else if (frame_start) begin
        addr_cnt <= '0;
      end

      if (frame_start) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end

      if (pixel_req)
        pixels <= pop ? fifo_mem[rd_ptr] : 8'h00;

      if (frame_start)
        underflow <= 1'b0;
      else if (pixel_req && (fifo_count == '0) && (state == FETCH))
        underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_data;
  end

  // Requests are only launched while FIFO + in-flight < DEPTH, so a returning
  // beat always has a free slot.
  push_never_full: assert property (@(posedge clk) disable iff (!reset)
    push |-> (fifo_count < CW'(DEPTH)));

endmodule

// File: tb/tb_vga_pixel_fetch.sv
module tb_vga_pixel_fetch;

  localparam int ADDR_W = 18;
  localparam int FB     = 16;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              frame_start = 1'b0;
  logic              pixel_req = 1'b0;
  logic [7:0]        pixels;
  logic              underflow;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic              mem_valid = 1'b0;
  logic [7:0]        mem_data = 8'h00;

  always #5 clk = ~clk;

  vga_pixel_fetch #(.ADDR_W(ADDR_W), .FRAME_BYTES(FB), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pixel_req(pixel_req),
    .pixels(pixels), .underflow(underflow), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_valid(mem_valid), .mem_data(mem_data)
  );

  int checks = 0;
  int failures = 0;

  // SRAM model: ack policy, fixed latency, in-order responses, data = base + addr.
  typedef struct { logic [ADDR_W-1:0] addr; int due; } resp_t;
  resp_t             resp_q[$];
  logic [ADDR_W-1:0] ack_log[$];
  int                cyc = 0;
  int                lat = 2;
  int                ack_mode = 1;   // 0 never, 1 always, 2 random (forced after 2 waits)
  int                wait_cnt = 0;
  logic [7:0]        data_base = 8'h00;
  bit                grant;

  logic              fs_rd, fs_uf;
  logic [ADDR_W-1:0] fs_addr;
  logic [7:0]        px;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      resp_q.delete();
      mem_valid = 1'b0;
      mem_ack   = 1'b0;
      wait_cnt  = 0;
    end else begin
      mem_valid = 1'b0;
      if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
        mem_valid = 1'b1;
        mem_data  = data_base + resp_q[0].addr[7:0];
        void'(resp_q.pop_front());
      end
      case (ack_mode)
        0:       grant = 1'b0;
        1:       grant = 1'b1;
        default: grant = ($urandom_range(0, 3) != 0) || (wait_cnt >= 2);
      endcase
      mem_ack = mem_rd && grant;
      if (mem_rd && !mem_ack) wait_cnt++;
      else wait_cnt = 0;
      if (mem_ack) begin
        resp_q.push_back('{addr: mem_addr, due: cyc + lat});
        ack_log.push_back(mem_addr);
      end
    end
  end

  function automatic logic [7:0] exp_byte(input int k);
    return data_base + 8'(k % FB);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_fs();
    @(negedge clk); frame_start = 1'b1;
    @(posedge clk); #1;
    fs_rd = mem_rd; fs_addr = mem_addr; fs_uf = underflow;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic req(output logic [7:0] p);
    @(negedge clk); pixel_req = 1'b1;
    @(posedge clk); #1; p = pixels;
    @(negedge clk); pixel_req = 1'b0;
  endtask

  task automatic wait_quiet();
    int stable = 0;
    int n = 0;
    while (stable < 4 && n < 400) begin
      @(posedge clk); #1; n++;
      if (resp_q.size() == 0 && mem_rd === 1'b0) stable++;
      else stable = 0;
    end
    checks++;
    if (stable < 4) begin
      failures++;
      $display("FAIL quiet_timeout got=busy exp=idle");
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (pixels !== 8'h00 || mem_rd !== 1'b0 || underflow !== 1'b0 || mem_addr !== '0) begin
      failures++;
      $display("FAIL reset_values got px=%h rd=%b uf=%b addr=%0d exp px=00 rd=0 uf=0 addr=0",
               pixels, mem_rd, underflow, mem_addr);
    end
    @(negedge clk); reset = 1'b1;
    repeat (8) begin @(posedge clk); #1; if (mem_rd !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL idle_no_rd got=%0d exp=0", bad); end
  endtask

  task automatic test_startup();
    @(posedge clk); #1;
    lat = 2; ack_mode = 1; data_base = 8'h00; ack_log.delete();
    pulse_fs();
    checks++;
    if (fs_rd !== 1'b1 || fs_addr !== '0) begin
      failures++;
      $display("FAIL first_rd_latency got rd=%b addr=%0d exp rd=1 addr=0", fs_rd, fs_addr);
    end
    idle(30);
    checks++;
    if (ack_log.size() != DEPTH) begin
      failures++;
      $display("FAIL startup_ack_count got=%0d exp=%0d", ack_log.size(), DEPTH);
    end
    for (int i = 0; i < ack_log.size(); i++) begin
      checks++;
      if (ack_log[i] !== ADDR_W'(i)) begin
        failures++;
        $display("FAIL startup_addr[%0d] got=%0d exp=%0d", i, ack_log[i], i);
      end
    end
    checks++;
    if (mem_rd !== 1'b0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL startup_full got rd=%b uf=%b exp rd=0 uf=0", mem_rd, underflow);
    end
  endtask

  task automatic test_streaming();
    int bad = 0;
    wait_quiet();
    lat = $urandom_range(1, 4); ack_mode = 2; data_base = 8'h00; ack_log.delete();
    pulse_fs();
    idle(20);
    for (int k = 0; k < 20; k++) begin
      req(px);
      checks++;
      if (px !== exp_byte(k)) begin
        failures++;
        $display("FAIL stream_px[%0d] got=%h exp=%h", k, px, exp_byte(k));
      end
      idle(7);
    end
    checks++;
    if (underflow !== 1'b0) begin failures++; $display("FAIL stream_underflow got=%b exp=0", underflow); end
    for (int i = 0; i < ack_log.size(); i++)
      if (ack_log[i] !== ADDR_W'(i % FB)) bad++;
    checks++;
    if (ack_log.size() < 20 || bad != 0) begin
      failures++;
      $display("FAIL stream_addr_seq got acks=%0d bad=%0d exp acks>=20 bad=0", ack_log.size(), bad);
    end
  endtask

  task automatic test_underflow();
    wait_quiet();
    ack_mode = 0; data_base = 8'h10; lat = 2;
    pulse_fs();
    idle(40);
    for (int k = 0; k < 2; k++) begin
      req(px);
      checks++;
      if (px !== 8'h00) begin failures++; $display("FAIL underflow_px[%0d] got=%h exp=00", k, px); end
    end
    checks++;
    if (underflow !== 1'b1) begin failures++; $display("FAIL underflow_flag got=%b exp=1", underflow); end
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== '0) begin
      failures++;
      $display("FAIL underflow_held_req got rd=%b addr=%0d exp rd=1 addr=0", mem_rd, mem_addr);
    end
    pulse_fs();
    checks++;
    if (fs_uf !== 1'b0) begin failures++; $display("FAIL underflow_clear got=%b exp=0", fs_uf); end
    @(posedge clk); #1; ack_mode = 1;
    wait_quiet();
    req(px);
    checks++;
    if (px !== exp_byte(0) || underflow !== 1'b0) begin
      failures++;
      $display("FAIL underflow_recover got px=%h uf=%b exp px=%h uf=0", px, underflow, exp_byte(0));
    end
  endtask

  task automatic test_flush();
    int n = 0;
    wait_quiet();
    data_base = 8'hA0; lat = 6; ack_mode = 1; ack_log.delete();
    pulse_fs();
    while (ack_log.size() < 3 && n < 50) begin @(posedge clk); #1; n++; end
    ack_mode = 0;
    checks++;
    if (ack_log.size() != 3) begin failures++; $display("FAIL flush_setup got=%0d exp=3", ack_log.size()); end
    pulse_fs();
    checks++;
    if (fs_rd !== 1'b1 || fs_addr !== ADDR_W'(3)) begin
      failures++;
      $display("FAIL flush_held_req got rd=%b addr=%0d exp rd=1 addr=3", fs_rd, fs_addr);
    end
    @(posedge clk); #1; ack_log.delete(); ack_mode = 1;
    wait_quiet();
    checks++;
    if (ack_log.size() < 3 || ack_log[0] !== ADDR_W'(3) || ack_log[1] !== '0 || ack_log[2] !== ADDR_W'(1)) begin
      failures++;
      $display("FAIL flush_restart_addr got n=%0d first=%0d second=%0d exp 3,0,1",
               ack_log.size(), ack_log[0], ack_log[1]);
    end
    for (int k = 0; k < 6; k++) begin
      req(px);
      checks++;
      if (px !== exp_byte(k)) begin
        failures++;
        $display("FAIL flush_px[%0d] got=%h exp=%h", k, px, exp_byte(k));
      end
      idle(7);
    end
  endtask

  task automatic test_pending();
    wait_quiet();
    data_base = 8'h30; lat = 1; ack_mode = 1;
    pulse_fs();
    wait_quiet();
    req(px);
    checks++;
    if (px !== exp_byte(0)) begin failures++; $display("FAIL pending_px0 got=%h exp=%h", px, exp_byte(0)); end
    wait_quiet();
    ack_mode = 0;
    req(px);
    checks++;
    if (px !== exp_byte(1)) begin failures++; $display("FAIL pending_px1 got=%h exp=%h", px, exp_byte(1)); end
    idle(2);
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== ADDR_W'(5)) begin
      failures++;
      $display("FAIL pending_setup got rd=%b addr=%0d exp rd=1 addr=5", mem_rd, mem_addr);
    end
    pulse_fs();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_rd !== 1'b1 || mem_addr !== ADDR_W'(5)) begin
        failures++;
        $display("FAIL pending_hold[%0d] got rd=%b addr=%0d exp rd=1 addr=5", i, mem_rd, mem_addr);
      end
    end
    ack_log.delete(); ack_mode = 1;
    wait_quiet();
    checks++;
    if (ack_log.size() < 3 || ack_log[0] !== ADDR_W'(5) || ack_log[1] !== '0 || ack_log[2] !== ADDR_W'(1)) begin
      failures++;
      $display("FAIL pending_addr_seq got n=%0d first=%0d second=%0d exp 5,0,1",
               ack_log.size(), ack_log[0], ack_log[1]);
    end
    req(px);
    checks++;
    if (px !== exp_byte(0)) begin failures++; $display("FAIL pending_discard got=%h exp=%h", px, exp_byte(0)); end
  endtask

  task automatic test_async_reset();
    int bad = 0;
    wait_quiet();
    data_base = 8'h50; lat = 3; ack_mode = 1;
    pulse_fs();
    wait_quiet();
    ack_mode = 0;
    req(px);
    checks++;
    if (px !== exp_byte(0)) begin failures++; $display("FAIL areset_pre_px got=%h exp=%h", px, exp_byte(0)); end
    @(posedge clk); #1;
    checks++;
    if (mem_rd !== 1'b1) begin failures++; $display("FAIL areset_pre_rd got=%b exp=1", mem_rd); end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (mem_rd !== 1'b0 || pixels !== 8'h00 || underflow !== 1'b0 || mem_addr !== '0) begin
      failures++;
      $display("FAIL areset_immediate got rd=%b px=%h uf=%b addr=%0d exp rd=0 px=00 uf=0 addr=0",
               mem_rd, pixels, underflow, mem_addr);
    end
    @(negedge clk); @(negedge clk); #2 reset = 1'b1;
    ack_mode = 1;
    repeat (20) begin @(posedge clk); #1; if (mem_rd !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL areset_idle_rd got=%0d exp=0", bad); end
    pulse_fs();
    checks++;
    if (fs_rd !== 1'b1 || fs_addr !== '0) begin
      failures++;
      $display("FAIL areset_restart got rd=%b addr=%0d exp rd=1 addr=0", fs_rd, fs_addr);
    end
    wait_quiet();
    req(px);
    checks++;
    if (px !== exp_byte(0)) begin failures++; $display("FAIL areset_post_px got=%h exp=%h", px, exp_byte(0)); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_streaming();
    test_underflow();
    test_flush();
    test_pending();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
